// File: rtl/pm_pkg.sv
// ---------------------------------------------------------------------------
// pm_pkg
// Shared definitions for the packet-generator slice: frame-generator FSM
// state encoding and the integer helpers used to size beat counters and
// work out how many bytes the final beat of a frame carries.
// No ports (package).
// ---------------------------------------------------------------------------
package pm_pkg;

  // Frame generator states: idle waiting for a start, or streaming a frame
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } pm_state_t;

  // Integer ceiling division, also used by the pacer's width calculation
  function automatic int ceilDiv(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Number of bus beats needed to carry a frame of 'size' bytes
  function automatic int beatCount(input int size, input int keepWidth);
    return ceilDiv(size, keepWidth);
  endfunction

  // Number of valid byte lanes on the final beat of a frame
  function automatic int lastBytes(input int size, input int keepWidth);
    return size - (beatCount(size, keepWidth) - 1) * keepWidth;
  endfunction

endpackage

// File: rtl/pm_frame_gen_if.sv
// ---------------------------------------------------------------------------
// pm_frame_gen_if
// AXI-Stream bundle carrying the generated test frames.
//   tdata  : DATA_WIDTH bits of frame data
//   tkeep  : DATA_WIDTH/8 byte enables
//   tvalid : beat valid (source)
//   tready : downstream ready (sink)
//   tlast  : last beat of a frame
// Modports: master (frame source), slave (frame sink).
// ---------------------------------------------------------------------------
interface pm_frame_gen_if
  import pm_pkg::*;
#(
  parameter int DATA_WIDTH = 64
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/pm_beat_fmt.sv
// ---------------------------------------------------------------------------
// pm_beat_fmt
// Purely combinational beat formatter. Given the beat index within a frame
// and the frame's sequence number it produces the bus word for that beat.
//   i_beat  : beat index within the frame (0 .. BEATS-1)
//   i_seq   : frame sequence number
//   o_tdata : beat data; lane k holds frame byte i_beat*KEEP_WIDTH+k
//   o_tkeep : byte enables (partial only on the final beat)
//   o_tlast : high on the final beat
// Frame byte i is i[7:0], except the first SEQ_WIDTH/8 bytes, which hold
// the sequence number little-endian. Disabled lanes drive zero.
// ---------------------------------------------------------------------------
module pm_beat_fmt
  import pm_pkg::*;
#(
  parameter int SIZE       = 64,
  parameter int DATA_WIDTH = 64,
  parameter int SEQ_WIDTH  = 32,
  parameter int BEAT_W     = 4
) (
  input  logic [BEAT_W-1:0]       i_beat,
  input  logic [SEQ_WIDTH-1:0]    i_seq,
  output logic [DATA_WIDTH-1:0]   o_tdata,
  output logic [DATA_WIDTH/8-1:0] o_tkeep,
  output logic                    o_tlast
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int BEATS      = beatCount(SIZE, KEEP_WIDTH);
  localparam int LAST_BYTES = lastBytes(SIZE, KEEP_WIDTH);
  localparam int SEQ_BYTES  = SEQ_WIDTH / 8;

  logic        w_isLast;
  logic [31:0] w_idx;

  assign w_isLast = (i_beat == BEAT_W'(BEATS - 1));
  assign o_tlast  = w_isLast;

  // Build each byte lane from its global frame byte index; the sequence
  // number overrides the counting pattern in the leading header bytes.
  always_comb begin
    o_tdata = '0;
    o_tkeep = '0;
    w_idx   = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      w_idx = 32'(i_beat) * 32'(KEEP_WIDTH) + 32'(k);
      if (!w_isLast || (k < LAST_BYTES)) begin
        o_tkeep[k]        = 1'b1;
        o_tdata[8*k +: 8] = w_idx[7:0];
        for (int j = 0; j < SEQ_BYTES; j++) begin
          if (w_idx == 32'(j)) begin
            o_tdata[8*k +: 8] = i_seq[8*j +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/pm_frame_gen.sv
// ---------------------------------------------------------------------------
// pm_frame_gen
// Emits one synthetic test frame of SIZE bytes per pacing tick on an
// AXI-Stream master. Ticks arriving mid-frame are queued in a saturating
// pending counter; ticks that find it full are counted as drops.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   enable      : generator enable; ticks ignored and backlog cleared when low
//   tick        : single-cycle pacing pulse
//   m_axis      : AXI-Stream master (pm_frame_gen_if.master)
//   busy        : high while a frame is being sent
//   frame_count : frames completed (saturating)
//   drop_count  : ticks lost to a full backlog (saturating)
// ---------------------------------------------------------------------------
module pm_frame_gen
  import pm_pkg::*;
#(
  parameter int SIZE          = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int SEQ_WIDTH     = 32,
  parameter int PENDING_WIDTH = 4,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  tick,
  pm_frame_gen_if.master        m_axis,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] frame_count,
  output logic [STAT_WIDTH-1:0] drop_count
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int BEATS      = beatCount(SIZE, KEEP_WIDTH);
  localparam int BEAT_W     = $clog2(BEATS + 1);

  pm_state_t              r_state;
  pm_state_t              w_stateNext;
  logic [BEAT_W-1:0]      r_beat;
  logic [BEAT_W-1:0]      w_beatNext;
  logic [SEQ_WIDTH-1:0]   r_seq;
  logic [SEQ_WIDTH-1:0]   w_seqNext;
  logic [PENDING_WIDTH-1:0] r_pending;
  logic [PENDING_WIDTH-1:0] w_pendingNext;
  logic [STAT_WIDTH-1:0]  r_frameCount;
  logic [STAT_WIDTH-1:0]  r_dropCount;

  logic w_tickIn;
  logic w_pendingNz;
  logic w_start;
  logic w_hs;
  logic w_lastHs;
  logic w_startNow;
  logic w_fromPending;
  logic w_tickQueued;
  logic w_drop;

  logic [DATA_WIDTH-1:0] w_fmtData;
  logic [KEEP_WIDTH-1:0] w_fmtKeep;
  logic                  w_fmtLast;

  assign w_tickIn    = enable && tick;
  assign w_pendingNz = (r_pending != '0);
  assign w_start     = w_tickIn || w_pendingNz;
  assign w_hs        = (r_state == SEND) && m_axis.tready;
  assign w_lastHs    = w_hs && (r_beat == BEAT_W'(BEATS - 1));

  // A start prefers the backlog; a fresh tick that is not itself starting
  // a frame goes into the backlog instead.
  assign w_fromPending = w_startNow && w_pendingNz;
  assign w_tickQueued  = w_tickIn && !(w_startNow && !w_pendingNz);

  // Next-state logic: start from IDLE, walk beats on each handshake, and
  // either chain straight into the next frame or fall back to IDLE.
  always_comb begin
    w_stateNext = r_state;
    w_beatNext  = r_beat;
    w_seqNext   = r_seq;
    w_startNow  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_stateNext = SEND;
          w_beatNext  = '0;
          w_startNow  = 1'b1;
        end
      end
      SEND: begin
        if (w_lastHs) begin
          w_seqNext  = r_seq + SEQ_WIDTH'(1);
          w_beatNext = '0;
          if (w_start) begin
            w_startNow = 1'b1;
          end else begin
            w_stateNext = IDLE;
          end
        end else if (w_hs) begin
          w_beatNext = r_beat + BEAT_W'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_beatNext  = '0;
      end
    endcase
  end

  // Backlog accounting: a simultaneous queue and consume cancel out, and a
  // tick that finds the counter full becomes a drop.
  always_comb begin
    w_pendingNext = r_pending;
    w_drop        = 1'b0;
    if (!enable) begin
      w_pendingNext = '0;
    end else if (w_tickQueued && !w_fromPending) begin
      if (&r_pending) begin
        w_drop = 1'b1;
      end else begin
        w_pendingNext = r_pending + PENDING_WIDTH'(1);
      end
    end else if (!w_tickQueued && w_fromPending) begin
      w_pendingNext = r_pending - PENDING_WIDTH'(1);
    end
  end

  // State register, backlog and saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_seq        <= '0;
      r_pending    <= '0;
      r_frameCount <= '0;
      r_dropCount  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_beat    <= w_beatNext;
      r_seq     <= w_seqNext;
      r_pending <= w_pendingNext;
      if (w_lastHs && !(&r_frameCount)) begin
        r_frameCount <= r_frameCount + STAT_WIDTH'(1);
      end
      if (w_drop && !(&r_dropCount)) begin
        r_dropCount <= r_dropCount + STAT_WIDTH'(1);
      end
    end
  end

  pm_beat_fmt #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .SEQ_WIDTH  (SEQ_WIDTH),
    .BEAT_W     (BEAT_W)
  ) u_beatFmt (
    .i_beat  (r_beat),
    .i_seq   (r_seq),
    .o_tdata (w_fmtData),
    .o_tkeep (w_fmtKeep),
    .o_tlast (w_fmtLast)
  );

  // Bus outputs are zero whenever no beat is offered, which also gives the
  // all-zero state straight out of reset.
  assign m_axis.tvalid = (r_state == SEND);
  assign m_axis.tdata  = m_axis.tvalid ? w_fmtData : '0;
  assign m_axis.tkeep  = m_axis.tvalid ? w_fmtKeep : '0;
  assign m_axis.tlast  = m_axis.tvalid && w_fmtLast;

  assign busy        = (r_state == SEND);
  assign frame_count = r_frameCount;
  assign drop_count  = r_dropCount;

endmodule
